// File: rtl/pipe_pkg.sv
// Shared encodings for the RISCyMCU pipeline front-end and hazard controller.
// Defining PIPE_FORWARD_EN enables EX/WB operand bypass in hazard_unit.
package pipe_pkg;

  localparam logic [1:0] BS_NONE = 2'b00;
  localparam logic [1:0] BS_COND = 2'b01;
  localparam logic [1:0] BS_JMPR = 2'b10;
  localparam logic [1:0] BS_REL  = 2'b11;

  localparam logic [1:0] MD_ALU  = 2'b00;
  localparam logic [1:0] MD_MEM  = 2'b01;
  localparam logic [1:0] MD_DBIT = 2'b10;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  // All-zero instruction word decodes as a NOP; sized down to INSTR_W at use.
  localparam logic [31:0] NOP_INSTR = 32'h0;

endpackage

// File: rtl/hazard_unit.sv
// RAW hazard compare of DOF sources against EX/WB destinations.
// With PIPE_FORWARD_EN defined it also produces bypass selects.
module hazard_unit
  import pipe_pkg::*;
#(
  parameter int REG_AW = 3
) (
  input  logic [REG_AW-1:0] i_dof_ra,
  input  logic [REG_AW-1:0] i_dof_rb,
  input  logic              i_use_a,
  input  logic              i_use_b,
  input  logic              i_ex_rw,
  input  logic [REG_AW-1:0] i_ex_da,
`ifdef PIPE_FORWARD_EN
  input  logic [1:0]        i_ex_md,
  input  logic              i_wb_rw,
  input  logic [REG_AW-1:0] i_wb_da,
`endif
  output logic              o_stall,
  output logic [1:0]        o_fwd_a,
  output logic [1:0]        o_fwd_b
);

  logic w_hit_ex_a;
  logic w_hit_ex_b;

  // Register 0 is hardwired zero, so writes to it never create a dependency.
  assign w_hit_ex_a = i_use_a & i_ex_rw & (i_ex_da != '0) & (i_ex_da == i_dof_ra);
  assign w_hit_ex_b = i_use_b & i_ex_rw & (i_ex_da != '0) & (i_ex_da == i_dof_rb);

`ifdef PIPE_FORWARD_EN
  logic w_hit_wb_a;
  logic w_hit_wb_b;

  assign w_hit_wb_a = i_use_a & i_wb_rw & (i_wb_da != '0) & (i_wb_da == i_dof_ra);
  assign w_hit_wb_b = i_use_b & i_wb_rw & (i_wb_da != '0) & (i_wb_da == i_dof_rb);

  // Only ALU results exist in EX; load and D-bit producers still need a bubble.
  assign o_stall = (w_hit_ex_a | w_hit_ex_b) & (i_ex_md != MD_ALU);

  always_comb begin
    o_fwd_a = FWD_RF;
    o_fwd_b = FWD_RF;
    if (w_hit_ex_a)      o_fwd_a = FWD_EX;
    else if (w_hit_wb_a) o_fwd_a = FWD_WB;
    if (w_hit_ex_b)      o_fwd_b = FWD_EX;
    else if (w_hit_wb_b) o_fwd_b = FWD_WB;
  end
`else
  assign o_stall = w_hit_ex_a | w_hit_ex_b;
  assign o_fwd_a = FWD_RF;
  assign o_fwd_b = FWD_RF;
`endif

endmodule

// File: rtl/pipe_ctrl.sv
// Four-stage pipeline front-end: PC chain, IR, DOF->EX->WB control registers,
// branch flush and profiling counters. PIPE_FORWARD_EN enables bypass selects.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 17,
  parameter int REG_AW  = 3,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INSTR_W-1:0] instr,
  input  logic [REG_AW-1:0]  dof_ra,
  input  logic [REG_AW-1:0]  dof_rb,
  input  logic               dof_use_a,
  input  logic               dof_use_b,
  input  logic               dof_rw,
  input  logic               dof_mw,
  input  logic               dof_ps,
  input  logic [REG_AW-1:0]  dof_da,
  input  logic [1:0]         dof_md,
  input  logic [1:0]         dof_bs,
  input  logic               ex_z,
  input  logic [PC_W-1:0]    br_target,
  input  logic [PC_W-1:0]    reg_target,
  input  logic               cnt_clr,
  output logic [PC_W-1:0]    pc,
  output logic [PC_W-1:0]    pc_1,
  output logic [PC_W-1:0]    pc_2,
  output logic [INSTR_W-1:0] ir,
  output logic               ex_rw,
  output logic               ex_mw,
  output logic               ex_ps,
  output logic [REG_AW-1:0]  ex_da,
  output logic [1:0]         ex_md,
  output logic [1:0]         ex_bs,
  output logic               wb_rw,
  output logic [REG_AW-1:0]  wb_da,
  output logic [1:0]         wb_md,
  output logic [1:0]         fwd_a,
  output logic [1:0]         fwd_b,
  output logic               stall,
  output logic               flush,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt
);

  logic [PC_W-1:0]    r_pc, r_pc_1, r_pc_2;
  logic [INSTR_W-1:0] r_ir;
  logic               r_ex_rw, r_ex_mw, r_ex_ps;
  logic [REG_AW-1:0]  r_ex_da;
  logic [1:0]         r_ex_md, r_ex_bs;
  logic               r_wb_rw;
  logic [REG_AW-1:0]  r_wb_da;
  logic [1:0]         r_wb_md;
  logic [CNT_W-1:0]   r_stall_cnt, r_flush_cnt;

  logic               w_stall, w_taken, w_hold, w_bubble;
  logic [PC_W-1:0]    w_target, w_pc_next;

  hazard_unit #(.REG_AW(REG_AW)) u_hazard (
    .i_dof_ra (dof_ra),
    .i_dof_rb (dof_rb),
    .i_use_a  (dof_use_a),
    .i_use_b  (dof_use_b),
    .i_ex_rw  (r_ex_rw),
    .i_ex_da  (r_ex_da),
`ifdef PIPE_FORWARD_EN
    .i_ex_md  (r_ex_md),
    .i_wb_rw  (r_wb_rw),
    .i_wb_da  (r_wb_da),
`endif
    .o_stall  (w_stall),
    .o_fwd_a  (fwd_a),
    .o_fwd_b  (fwd_b)
  );

  assign w_taken  = ((r_ex_bs == BS_COND) & (r_ex_ps ^ ex_z)) | r_ex_bs[1];
  assign w_target = (r_ex_bs == BS_JMPR) ? reg_target : br_target;
  // A taken branch kills the stalled DOF instruction anyway, so flush overrides hold.
  assign w_hold   = w_stall & ~w_taken;
  assign w_bubble = w_stall | w_taken;

  always_comb begin
    w_pc_next = r_pc + PC_W'(1);
    if (w_taken)     w_pc_next = w_target;
    else if (w_hold) w_pc_next = r_pc;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc   <= '0;
      r_pc_1 <= '0;
      r_pc_2 <= '0;
      r_ir   <= '0;
    end else begin
      r_pc <= w_pc_next;
      if (!w_hold) begin
        r_pc_1 <= r_pc + PC_W'(1);
        r_pc_2 <= r_pc_1;
        r_ir   <= w_taken ? INSTR_W'(NOP_INSTR) : instr;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ex_rw <= 1'b0;
      r_ex_mw <= 1'b0;
      r_ex_ps <= 1'b0;
      r_ex_da <= '0;
      r_ex_md <= '0;
      r_ex_bs <= '0;
      r_wb_rw <= 1'b0;
      r_wb_da <= '0;
      r_wb_md <= '0;
    end else begin
      r_ex_rw <= dof_rw & ~w_bubble;
      r_ex_mw <= dof_mw & ~w_bubble;
      r_ex_ps <= dof_ps;
      r_ex_da <= w_bubble ? '0 : dof_da;
      r_ex_md <= dof_md;
      r_ex_bs <= w_bubble ? BS_NONE : dof_bs;
      r_wb_rw <= r_ex_rw;
      r_wb_da <= r_ex_da;
      r_wb_md <= r_ex_md;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (cnt_clr) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_taken && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign pc        = r_pc;
  assign pc_1      = r_pc_1;
  assign pc_2      = r_pc_2;
  assign ir        = r_ir;
  assign ex_rw     = r_ex_rw;
  assign ex_mw     = r_ex_mw;
  assign ex_ps     = r_ex_ps;
  assign ex_da     = r_ex_da;
  assign ex_md     = r_ex_md;
  assign ex_bs     = r_ex_bs;
  assign wb_rw     = r_wb_rw;
  assign wb_da     = r_wb_da;
  assign wb_md     = r_wb_md;
  assign stall     = w_stall;
  assign flush     = w_taken;
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed scoreboard bench for pipe_ctrl; expectations follow PIPE_FORWARD_EN
// when the bench is compiled with that macro.
module tb_pipe_ctrl;

  localparam int PC_W    = 8;
  localparam int INSTR_W = 17;
  localparam int REG_AW  = 3;
  localparam int CNT_W   = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic [INSTR_W-1:0] instr;
  logic [REG_AW-1:0]  dofRa = '0, dofRb = '0, dofDa = '0;
  logic               dofUseA = 1'b0, dofUseB = 1'b0, dofRw = 1'b0, dofMw = 1'b0, dofPs = 1'b0;
  logic [1:0]         dofMd = '0, dofBs = '0;
  logic               exZ = 1'b0;
  logic [PC_W-1:0]    brTarget = '0, regTarget = '0;
  logic               cntClr = 1'b0;
  logic [PC_W-1:0]    pc, pc1, pc2;
  logic [INSTR_W-1:0] ir;
  logic               exRw, exMw, exPs, wbRw, stall, flush;
  logic [REG_AW-1:0]  exDa, wbDa;
  logic [1:0]         exMd, exBs, wbMd, fwdA, fwdB;
  logic [CNT_W-1:0]   stallCnt, flushCnt;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } expItem_t;

  expItem_t    scoreboard[$];
  int          evaluated = 0;
  int          failures  = 0;
  logic [PC_W-1:0] expPc = '0;

  always #5 clk = ~clk;

  // Instruction memory model: a recognisable tag above the fetch address.
  assign instr = {9'h155, pc};

  pipe_ctrl #(.PC_W(PC_W), .INSTR_W(INSTR_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .instr(instr),
    .dof_ra(dofRa), .dof_rb(dofRb), .dof_use_a(dofUseA), .dof_use_b(dofUseB),
    .dof_rw(dofRw), .dof_mw(dofMw), .dof_ps(dofPs), .dof_da(dofDa),
    .dof_md(dofMd), .dof_bs(dofBs), .ex_z(exZ),
    .br_target(brTarget), .reg_target(regTarget), .cnt_clr(cntClr),
    .pc(pc), .pc_1(pc1), .pc_2(pc2), .ir(ir),
    .ex_rw(exRw), .ex_mw(exMw), .ex_ps(exPs), .ex_da(exDa), .ex_md(exMd), .ex_bs(exBs),
    .wb_rw(wbRw), .wb_da(wbDa), .wb_md(wbMd),
    .fwd_a(fwdA), .fwd_b(fwdB), .stall(stall), .flush(flush),
    .stall_cnt(stallCnt), .flush_cnt(flushCnt)
  );

  task automatic pushExp(input string tag, input logic [31:0] val);
    expItem_t item;
    item.tag = tag;
    item.val = val;
    scoreboard.push_back(item);
  endtask

  task automatic checkOutput(input logic [31:0] observed);
    expItem_t item;
    evaluated++;
    if (scoreboard.size() == 0) begin
      failures++;
      $error("[TB] FAIL scoreboardEmpty observed=%0h expected=none", observed);
    end else begin
      item = scoreboard.pop_front();
      assert (observed === item.val) else begin
        failures++;
        $error("[TB] FAIL %s observed=%0h expected=%0h", item.tag, observed, item.val);
      end
    end
  endtask

  task automatic applyStimulus(input logic [2:0] ra, input logic useA, input logic [2:0] rb,
                               input logic useB, input logic rw, input logic [2:0] da,
                               input logic [1:0] md, input logic [1:0] bs, input logic ps);
    dofRa = ra; dofUseA = useA; dofRb = rb; dofUseB = useB;
    dofRw = rw; dofMw = rw; dofDa = da; dofMd = md; dofBs = bs; dofPs = ps;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic advance();
    tick();
    expPc = expPc + 8'd1;
  endtask

  task automatic jumpTo(input logic [PC_W-1:0] t);
    tick();
    expPc = t;
  endtask

  initial begin
    // Reset held with random inputs: everything must read zero.
    for (int i = 0; i < 3; i++) begin
      dofRa = REG_AW'($urandom); dofRb = REG_AW'($urandom); dofDa = REG_AW'($urandom);
      dofUseA = 1'($urandom); dofUseB = 1'($urandom); dofRw = 1'($urandom);
      dofMd = 2'($urandom); dofBs = 2'($urandom); exZ = 1'($urandom);
      brTarget = PC_W'($urandom); regTarget = PC_W'($urandom); cntClr = 1'($urandom);
      pushExp("rstPcChain", 0);
      pushExp("rstIr", 0);
      pushExp("rstExWb", 0);
      pushExp("rstStatus", 0);
      pushExp("rstCounters", 0);
      tick();
      checkOutput({8'h0, pc, pc1, pc2});
      checkOutput(32'(ir));
      checkOutput({exRw, exMw, exPs, exDa, exMd, exBs, wbRw, wbDa, wbMd});
      checkOutput({fwdA, fwdB, stall, flush});
      checkOutput({stallCnt, flushCnt});
    end
    cntClr = 1'b0; exZ = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2 rst = 1'b1;
    pushExp("pcAfterRelease", 0);
    checkOutput(32'(pc));

    // NOP sequence from address 0.
    for (int k = 1; k <= 4; k++) begin
      pushExp("pcNop", k);
      advance();
      checkOutput(32'(pc));
    end
    pushExp("pc1Nop", 4); pushExp("pc2Nop", 3); pushExp("irNop", {15'h0, 9'h155, 8'd3});
    pushExp("stallCntNop", 0);
    checkOutput(32'(pc1)); checkOutput(32'(pc2)); checkOutput(32'(ir)); checkOutput(32'(stallCnt));

    // ALU producer in EX, consumer on operand A.
    applyStimulus(0, 0, 0, 0, 1, 3, 2'b00, 0, 0);
    advance();
    applyStimulus(3, 1, 0, 0, 1, 5, 2'b00, 0, 0);
`ifdef PIPE_FORWARD_EN
    pushExp("aluFwdA", 2'b01); pushExp("aluStall", 0);
`else
    pushExp("aluFwdA", 2'b00); pushExp("aluStall", 1);
`endif
    checkOutput(32'(fwdA)); checkOutput(32'(stall));
`ifdef PIPE_FORWARD_EN
    advance();
    pushExp("aluPc", 32'(expPc)); pushExp("aluExRw", 1); pushExp("aluExDa", 5);
    pushExp("aluStallCnt", 0);
`else
    tick();
    pushExp("aluPcHeld", 32'(expPc)); pushExp("aluExRw", 0); pushExp("aluExDa", 0);
    pushExp("aluStallCnt", 1);
`endif
    checkOutput(32'(pc)); checkOutput(32'(exRw)); checkOutput(32'(exDa)); checkOutput(32'(stallCnt));
    pushExp("aluWb", {1'b1, 3'd3});
    checkOutput({28'h0, wbRw, wbDa});
`ifdef PIPE_FORWARD_EN
    pushExp("aluWbFwdA", 2'b10);
`else
    pushExp("aluWbFwdA", 2'b00);
`endif
    pushExp("aluWbStall", 0);
    checkOutput(32'(fwdA)); checkOutput(32'(stall));

    // Writes to register 0 never hazard.
    applyStimulus(0, 0, 0, 0, 1, 0, 2'b01, 0, 0);
    advance();
    applyStimulus(0, 1, 0, 1, 0, 0, 2'b00, 0, 0);
    pushExp("r0Stall", 0); pushExp("r0Fwd", 0);
    checkOutput(32'(stall)); checkOutput({fwdA, fwdB});

`ifdef PIPE_FORWARD_EN
    // EX result takes priority over an older WB result for the same register.
    applyStimulus(0, 0, 0, 0, 1, 3, 2'b00, 0, 0);
    advance();
    advance();
    applyStimulus(3, 1, 0, 0, 0, 0, 2'b00, 0, 0);
    pushExp("prioFwdA", 2'b01); pushExp("prioStall", 0);
    checkOutput(32'(fwdA)); checkOutput(32'(stall));
`endif

    // Clear counters.
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cntClr = 1'b1;
    advance();
    cntClr = 1'b0;
    pushExp("clrCounters", 0);
    checkOutput({stallCnt, flushCnt});

    // Load producer: stall in both builds, then WB hit.
    applyStimulus(0, 0, 0, 0, 1, 2, 2'b01, 0, 0);
    advance();
    applyStimulus(0, 0, 2, 1, 0, 0, 2'b00, 0, 0);
    pushExp("loadStall", 1);
    checkOutput(32'(stall));
    tick();
    pushExp("loadPcHeld", 32'(expPc)); pushExp("loadStallCnt", 1); pushExp("loadWb", {1'b1, 3'd2, 2'b01});
    pushExp("loadWbStall", 0);
`ifdef PIPE_FORWARD_EN
    pushExp("loadFwdB", 2'b10);
`else
    pushExp("loadFwdB", 2'b00);
`endif
    checkOutput(32'(pc)); checkOutput(32'(stallCnt)); checkOutput({26'h0, wbRw, wbDa, wbMd});
    checkOutput(32'(stall)); checkOutput(32'(fwdB));

    // Conditional branch taken (ps=0, z=1).
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    advance();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 2'b01, 0);
    advance();
    applyStimulus(0, 0, 0, 0, 1, 6, 0, 0, 0);
    exZ = 1'b1; brTarget = 8'h40; regTarget = 8'h99;
    #1;
    pushExp("brFlush", 1);
    checkOutput(32'(flush));
    jumpTo(8'h40);
    pushExp("brPc", 8'h40); pushExp("brIr", 0); pushExp("brExBubble", 0); pushExp("brFlushCnt", 1);
    pushExp("brFlushAfter", 0);
    checkOutput(32'(pc)); checkOutput(32'(ir)); checkOutput({exRw, exMw, exDa, exBs});
    checkOutput(32'(flushCnt)); checkOutput(32'(flush));

    // Conditional branch not taken (ps=0, z=0).
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 2'b01, 0);
    advance();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    exZ = 1'b0;
    #1;
    pushExp("brNotFlush", 0);
    checkOutput(32'(flush));
    advance();
    pushExp("brNotPc", 32'(expPc));
    checkOutput(32'(pc));

    // Conditional branch taken on inverted polarity (ps=1, z=0).
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 2'b01, 1);
    advance();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    exZ = 1'b0; brTarget = 8'h55;
    #1;
    pushExp("brPolFlush", 1);
    checkOutput(32'(flush));
    jumpTo(8'h55);
    pushExp("brPolPc", 8'h55); pushExp("brPolFlushCnt", 2);
    checkOutput(32'(pc)); checkOutput(32'(flushCnt));

    // Load + jump-register in EX with dependent DOF: flush wins over stall.
    applyStimulus(0, 0, 0, 0, 1, 3, 2'b01, 2'b10, 0);
    advance();
    applyStimulus(3, 1, 0, 0, 0, 0, 2'b00, 0, 0);
    regTarget = 8'h10; brTarget = 8'h77;
    #1;
    pushExp("bothStall", 1); pushExp("bothFlush", 1);
    checkOutput(32'(stall)); checkOutput(32'(flush));
    jumpTo(8'h10);
    pushExp("bothPc", 8'h10); pushExp("bothStallCnt", 2); pushExp("bothFlushCnt", 3); pushExp("bothIr", 0);
    checkOutput(32'(pc)); checkOutput(32'(stallCnt)); checkOutput(32'(flushCnt)); checkOutput(32'(ir));

    // Saturate the stall counter with 20 stalls.
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cntClr = 1'b1;
    advance();
    cntClr = 1'b0;
    for (int s = 0; s < 20; s++) begin
      applyStimulus(0, 0, 0, 0, 1, 3, 2'b01, 0, 0);
      advance();
      applyStimulus(3, 1, 0, 0, 0, 0, 2'b00, 0, 0);
      pushExp("satStall", 1);
      checkOutput(32'(stall));
      tick();
    end
    pushExp("satStallCnt", 4'hF);
    checkOutput(32'(stallCnt));

    // Clear wins over a simultaneous stall increment.
    applyStimulus(0, 0, 0, 0, 1, 3, 2'b01, 0, 0);
    advance();
    applyStimulus(3, 1, 0, 0, 0, 0, 2'b00, 0, 0);
    cntClr = 1'b1;
    pushExp("clrStall", 1);
    checkOutput(32'(stall));
    tick();
    cntClr = 1'b0;
    pushExp("clrWinsCnt", 0);
    checkOutput({stallCnt, flushCnt});

    evaluated++;
    assert (scoreboard.size() == 0) else begin
      failures++;
      $error("[TB] FAIL scoreboardLeftover observed=%0d expected=0", scoreboard.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", evaluated, failures);
    $finish;
  end

endmodule
